inval_burst_sequencer: RTL and testbench

INVAL_BURST_SEQUENCER -- requirements
Module: inval_burst_sequencer

---
 rtl/ara_pkg.sv | 30 +++
 rtl/fifo_v3.sv | 83 ++++++++
 rtl/inval_burst_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_inval_burst_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ara_pkg.sv
// -----------------------------------------------------------------------------
// ara_pkg
// Shared types for the invalidation burst sequencer:
//   burst_desc_t : queued write-burst descriptor (address, AXI len, AXI size)
//   seq_state_e  : sequencer FSM state
//   burst_bytes  : byte count covered by one AXI burst
// Descriptor addresses are stored at MaxAddrWidth bits; users with a narrower
// address zero-extend into the field.
// -----------------------------------------------------------------------------
package ara_pkg;

    localparam int unsigned MaxAddrWidth = 64;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
    } burst_desc_t;

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_ISSUE = 1'b1
    } seq_state_e;

    // (len + 1) beats of 2**size bytes; at most 256 << 7 = 32768, fits 16 bits.
    function automatic logic [15:0] burst_bytes(input logic [7:0] len, input logic [2:0] size);
        return (16'(len) + 16'd1) << size;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// -----------------------------------------------------------------------------
// fifo_v3
// Non-fall-through FIFO with the common_cells naming. data_o shows the head
// entry whenever empty_o is low; pushes when full and pops when empty are
// ignored.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   flush_i : synchronous clear of all entries
//   full_o  : no free entry
//   empty_o : no valid entry
//   data_i  : write data, push_i : write strobe
//   data_o  : head entry, pop_i  : remove head
// -----------------------------------------------------------------------------
module fifo_v3 #(
    parameter int unsigned DEPTH = 8,
    parameter type         dtype = logic [31:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AddrDepth-1:0] LastIdx = AddrDepth'(DEPTH - 1);
    localparam logic [AddrDepth-1:0] PtrZero = AddrDepth'(32'd0);
    localparam logic [AddrDepth-1:0] PtrOne  = AddrDepth'(32'd1);
    localparam logic [AddrDepth:0]   CntFull = (AddrDepth + 1)'(DEPTH);
    localparam logic [AddrDepth:0]   CntZero = (AddrDepth + 1)'(32'd0);
    localparam logic [AddrDepth:0]   CntOne  = (AddrDepth + 1)'(32'd1);

    dtype                 mem_r [DEPTH];
    logic [AddrDepth-1:0] rd_ptr_r;
    logic [AddrDepth-1:0] wr_ptr_r;
    logic [AddrDepth:0]   cnt_r;
    logic                 do_push_s;
    logic                 do_pop_s;

    assign full_o    = (cnt_r == CntFull);
    assign empty_o   = (cnt_r == CntZero);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign data_o    = mem_r[rd_ptr_r];

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_r <= PtrZero;
            wr_ptr_r <= PtrZero;
            cnt_r    <= CntZero;
        end else if (flush_i) begin
            rd_ptr_r <= PtrZero;
            wr_ptr_r <= PtrZero;
            cnt_r    <= CntZero;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= (wr_ptr_r == LastIdx) ? PtrZero : (wr_ptr_r + PtrOne);
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LastIdx) ? PtrZero : (rd_ptr_r + PtrOne);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_r <= cnt_r + CntOne;
                2'b01:   cnt_r <= cnt_r - CntOne;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Storage array; contents are only meaningful between push and pop.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/inval_burst_sequencer.sv
// -----------------------------------------------------------------------------
// inval_burst_sequencer
// Turns AXI write-burst descriptors into a stream of L1 line invalidations.
// Descriptors are queued in a FIFO; an FSM walks each burst from its first to
// its last touched line, one request per line, and pulses done_o per burst.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   en_i              : coherence enable; when low descriptors are acked and dropped
//   req_valid_i/ready : descriptor handshake (req_addr_i, req_len_i, req_size_i)
//   inval_valid_o/... : line invalidation handshake (inval_addr_o line-aligned)
//   done_o            : one-cycle pulse after the last line of a burst
//   busy_o            : work queued or in progress
// Build option:
//   INVAL_COALESCE_EN : skip any line equal to the last line the core accepted
// AddrWidth must not exceed ara_pkg::MaxAddrWidth.
// -----------------------------------------------------------------------------
module inval_burst_sequencer
    import ara_pkg::*;
#(
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned L1LineWidth = 16,
    parameter int unsigned Depth       = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic [7:0]           req_len_i,
    input  logic [2:0]           req_size_i,
    output logic                 inval_valid_o,
    input  logic                 inval_ready_i,
    output logic [AddrWidth-1:0] inval_addr_o,
    output logic                 done_o,
    output logic                 busy_o
);

    localparam logic [AddrWidth-1:0] AddrZero = AddrWidth'(32'd0);
    localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(32'd1);
    localparam logic [AddrWidth-1:0] LineStep = AddrWidth'(L1LineWidth);
    localparam logic [AddrWidth-1:0] LineMask = ~(LineStep - AddrOne);

    seq_state_e           state_r;
    seq_state_e           state_nxt_s;
    logic [AddrWidth-1:0] cur_r;
    logic [AddrWidth-1:0] cur_nxt_s;
    logic [AddrWidth-1:0] end_r;
    logic [AddrWidth-1:0] end_nxt_s;
    logic                 done_r;
    logic                 done_nxt_s;

    burst_desc_t          push_desc_s;
    burst_desc_t          head_desc_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 fifo_push_s;
    logic                 fifo_pop_s;

    logic [AddrWidth-1:0] head_addr_s;
    logic [AddrWidth-1:0] head_start_s;
    logic [AddrWidth-1:0] head_last_s;
    logic                 skip_s;
    logic                 issue_s;
    logic                 advance_s;

    // While disabled every descriptor is acked so the producer never stalls.
    assign req_ready_o = !rst_i && (!en_i || !fifo_full_s);
    assign fifo_push_s = req_valid_i && req_ready_o && en_i;

    assign push_desc_s.addr = MaxAddrWidth'(req_addr_i);
    assign push_desc_s.len  = req_len_i;
    assign push_desc_s.size = req_size_i;

    // Line range of the FIFO head; the end address wraps modulo 2^AddrWidth.
    assign head_addr_s  = head_desc_s.addr[AddrWidth-1:0];
    assign head_start_s = head_addr_s & LineMask;
    assign head_last_s  = (head_addr_s + AddrWidth'(burst_bytes(head_desc_s.len, head_desc_s.size))
                           - AddrOne) & LineMask;

    fifo_v3 #(
        .DEPTH (Depth),
        .dtype (burst_desc_t)
    ) i_desc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (1'b1),
        .flush_i (rst_i),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .data_i  (push_desc_s),
        .push_i  (fifo_push_s),
        .data_o  (head_desc_s),
        .pop_i   (fifo_pop_s)
    );

`ifdef INVAL_COALESCE_EN
    logic [AddrWidth-1:0] last_line_r;
    logic                 last_vld_r;

    // A repeat of the line the core just accepted is retired without a request.
    assign skip_s = (state_r == SEQ_ISSUE) && last_vld_r && (cur_r == last_line_r);

    // Remember the most recent line the core actually accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_line_r <= AddrZero;
            last_vld_r  <= 1'b0;
        end else if (issue_s && inval_ready_i) begin
            last_line_r <= cur_r;
            last_vld_r  <= 1'b1;
        end
    end
`else
    assign skip_s = 1'b0;
`endif

    assign issue_s   = (state_r == SEQ_ISSUE) && !skip_s;
    assign advance_s = skip_s || (issue_s && inval_ready_i);

    // Next-state: load bursts from the FIFO head and step through their lines.
    always_comb begin
        state_nxt_s = state_r;
        cur_nxt_s   = cur_r;
        end_nxt_s   = end_r;
        done_nxt_s  = 1'b0;
        fifo_pop_s  = 1'b0;
        case (state_r)
            SEQ_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s  = 1'b1;
                    cur_nxt_s   = head_start_s;
                    end_nxt_s   = head_last_s;
                    state_nxt_s = SEQ_ISSUE;
                end else begin
                    state_nxt_s = SEQ_IDLE;
                end
            end
            SEQ_ISSUE: begin
                if (!advance_s) begin
                    state_nxt_s = SEQ_ISSUE;
                end else if (cur_r != end_r) begin
                    cur_nxt_s = cur_r + LineStep;
                end else begin
                    done_nxt_s = 1'b1;
                    // Chain straight into the next burst so no idle cycle appears.
                    if (!fifo_empty_s) begin
                        fifo_pop_s  = 1'b1;
                        cur_nxt_s   = head_start_s;
                        end_nxt_s   = head_last_s;
                        state_nxt_s = SEQ_ISSUE;
                    end else begin
                        state_nxt_s = SEQ_IDLE;
                    end
                end
            end
            default: begin
                state_nxt_s = SEQ_IDLE;
            end
        endcase
    end

    // State, line cursor and done pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= SEQ_IDLE;
            cur_r   <= AddrZero;
            end_r   <= AddrZero;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cur_r   <= cur_nxt_s;
            end_r   <= end_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign inval_valid_o = issue_s;
    assign inval_addr_o  = cur_r;
    assign done_o        = done_r;
    assign busy_o        = !rst_i && (!fifo_empty_s || (state_r != SEQ_IDLE));

endmodule

// File: tb/tb_inval_burst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inval_burst_sequencer
// Directed vector table, hand-written corner sequences and a randomized run
// checked against a line-list model of the sequencer (L1LineWidth=16, Depth=4).
// -----------------------------------------------------------------------------
module tb_inval_burst_sequencer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_addr_i;
    logic [7:0]  req_len_i;
    logic [2:0]  req_size_i;
    logic        inval_valid_o;
    logic        inval_ready_i;
    logic [63:0] inval_addr_o;
    logic        done_o;
    logic        busy_o;

    always #5 clk = ~clk;

    inval_burst_sequencer #(
        .AddrWidth   (64),
        .L1LineWidth (16),
        .Depth       (4)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_len_i     (req_len_i),
        .req_size_i    (req_size_i),
        .inval_valid_o (inval_valid_o),
        .inval_ready_i (inval_ready_i),
        .inval_addr_o  (inval_addr_o),
        .done_o        (done_o),
        .busy_o        (busy_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: list of lines per accepted burst -----
    logic [63:0] exp_q[$];
    int          exp_done = 0;
    int          seen_done = 0;
    logic        mon_en = 1'b0;
    logic [63:0] model_last = 64'd0;
    logic        model_last_vld = 1'b0;

    function automatic void model_add(input logic [63:0] addr, input int len, input int size);
        logic [63:0] nbytes;
        logic [63:0] first;
        logic [63:0] last;
        logic [63:0] line;
        bit          skip;
        nbytes = 64'(len + 1) * (64'd1 << size);
        first  = addr - (addr % 64'd16);
        last   = addr + nbytes - 64'd1;
        last   = last - (last % 64'd16);
        line   = first;
        for (int k = 0; k < 4096; k++) begin
            skip = 1'b0;
`ifdef INVAL_COALESCE_EN
            skip = model_last_vld && (line == model_last);
`endif
            if (!skip) begin
                exp_q.push_back(line);
                model_last     = line;
                model_last_vld = 1'b1;
            end
            if (line == last) break;
            line = line + 64'd16;
        end
        exp_done++;
    endfunction

    // Scoreboard: every presented line must be the model's next line.
    always @(negedge clk) begin
        if (mon_en) begin
            if (inval_valid_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_unexpected_inval: got 0x%0h expected no request", inval_addr_o);
                end else begin
                    check("rand_inval_addr", inval_addr_o, exp_q[0]);
                    if (inval_ready_i) void'(exp_q.pop_front());
                end
            end
            if (done_o) seen_done++;
            if (req_valid_i && req_ready_o && en_i) model_add(req_addr_i, int'(req_len_i), int'(req_size_i));
        end
    end

    // ---------------- directed vector table ---------------------------------
    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [63:0] first;
        logic [63:0] last;
        int          n;
    } vec_t;

    vec_t vecs[7];

    task automatic do_reset();
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_last_vld = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          c;
        int          n;
        int          first_c;
        int          last_hs_c;
        int          done_c;
        logic [63:0] first_a;
        logic [63:0] last_a;
        @(posedge clk); #1;
        en_i = 1'b1; inval_ready_i = 1'b1;
        req_valid_i = 1'b1; req_addr_i = v.addr; req_len_i = v.len; req_size_i = v.size;
        @(negedge clk);
        check($sformatf("v%0d_ready", idx), 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        c = 0; n = 0; first_c = -1; last_hs_c = -1; done_c = -1;
        first_a = 64'd0; last_a = 64'd0;
        while (c < 400 && done_c < 0) begin
            @(negedge clk);
            c++;
            if (inval_valid_o && inval_ready_i) begin
                if (n == 0) begin
                    first_c = c;
                    first_a = inval_addr_o;
                end
                last_a    = inval_addr_o;
                last_hs_c = c;
                n++;
            end
            if (done_o) done_c = c;
        end
        check($sformatf("v%0d_first", idx), first_a, v.first);
        check($sformatf("v%0d_last", idx), last_a, v.last);
        check($sformatf("v%0d_count", idx), 64'(n), 64'(v.n));
        check($sformatf("v%0d_latency", idx), 64'(first_c), 64'd2);
        check($sformatf("v%0d_done_cycle", idx), 64'(done_c), 64'(last_hs_c + 1));
        @(negedge clk);
        check($sformatf("v%0d_done_single", idx), 64'(done_o), 64'd0);
        check($sformatf("v%0d_idle", idx), 64'(busy_o), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          k;
        int          hs;
        int          dn;
        int          bad;
        logic [63:0] exp_a;

        vecs[0] = '{64'h1000, 8'd3, 3'd3, 64'h1000, 64'h1010, 2};
        vecs[1] = '{64'h100C, 8'd0, 3'd3, 64'h1000, 64'h1010, 2};
        vecs[2] = '{64'h1004, 8'd0, 3'd2, 64'h1000, 64'h1000, 1};
        vecs[3] = '{64'h2000, 8'd15, 3'd2, 64'h2000, 64'h2030, 4};
        vecs[4] = '{64'h3008, 8'd255, 3'd0, 64'h3000, 64'h3100, 17};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 2};
        vecs[6] = '{64'h40, 8'd0, 3'd7, 64'h40, 64'hB0, 8};

        rst_i = 1'b1; en_i = 1'b1; req_valid_i = 1'b0; req_addr_i = 64'd0;
        req_len_i = 8'd0; req_size_i = 3'd0; inval_ready_i = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(inval_valid_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_addr", inval_addr_o, 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready_o), 64'd1);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Backpressure: request held for 5 stalled cycles.
        @(posedge clk); #1;
        inval_ready_i = 1'b0; req_valid_i = 1'b1;
        req_addr_i = 64'h1000; req_len_i = 8'd3; req_size_i = 3'd3;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        k = 0;
        while (!inval_valid_o && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_valid%0d", i), 64'(inval_valid_o), 64'd1);
            check($sformatf("hold_addr%0d", i), inval_addr_o, 64'h1000);
            @(posedge clk); #1;
        end
        inval_ready_i = 1'b1;
        @(negedge clk);
        check("hold_release_addr", inval_addr_o, 64'h1000);
        @(negedge clk);
        check("hold_second_addr", inval_addr_o, 64'h1010);
        check("hold_second_valid", 64'(inval_valid_o), 64'd1);
        @(negedge clk);
        check("hold_done", 64'(done_o), 64'd1);
        check("hold_valid_after", 64'(inval_valid_o), 64'd0);

        // Six back-to-back descriptors while the core stalls.
        @(posedge clk); #1;
        inval_ready_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            req_valid_i = 1'b1; req_addr_i = 64'h5000 + 64'(i) * 64'h100;
            req_len_i = 8'd0; req_size_i = 3'd0;
            @(negedge clk);
            check($sformatf("b2b_ready%0d", i), 64'(req_ready_o), (i < 5) ? 64'd1 : 64'd0);
            if (req_ready_o) acc++;
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        check("b2b_accepted", 64'(acc), 64'd5);
        @(negedge clk);
        check("b2b_busy", 64'(busy_o), 64'd1);
        check("b2b_valid", 64'(inval_valid_o), 64'd1);
        check("b2b_head", inval_addr_o, 64'h5000);
        @(posedge clk); #1;
        inval_ready_i = 1'b1;
        hs = 0; dn = 0; k = 0;
        while (k < 40 && dn < 5) begin
            @(negedge clk);
            k++;
            if (inval_valid_o && inval_ready_i) begin
                exp_a = 64'h5000 + 64'(hs) * 64'h100;
                check($sformatf("b2b_line%0d", hs), inval_addr_o, exp_a);
                hs++;
            end
            if (done_o) dn++;
        end
        check("b2b_handshakes", 64'(hs), 64'd5);
        check("b2b_dones", 64'(dn), 64'd5);

        // Disabled coherence: descriptor acked and dropped.
        @(posedge clk); #1;
        en_i = 1'b0; req_valid_i = 1'b1;
        req_addr_i = 64'h2000; req_len_i = 8'd7; req_size_i = 3'd3;
        @(negedge clk);
        check("en0_ready", 64'(req_ready_o), 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (inval_valid_o || busy_o || done_o) bad++;
        end
        check("en0_quiet", 64'(bad), 64'd0);
        @(posedge clk); #1;
        en_i = 1'b1;

        // Reset in the middle of a long burst.
        req_valid_i = 1'b1; req_addr_i = 64'h3000; req_len_i = 8'd255; req_size_i = 3'd0;
        inval_ready_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_active", 64'(inval_valid_o), 64'd1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(negedge clk);
        check("midrst_ready_in_rst", 64'(req_ready_o), 64'd0);
        check("midrst_busy_in_rst", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        model_last_vld = 1'b0;
        @(negedge clk);
        check("midrst_valid", 64'(inval_valid_o), 64'd0);
        check("midrst_addr", inval_addr_o, 64'd0);
        check("midrst_done", 64'(done_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_ready", 64'(req_ready_o), 64'd1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (inval_valid_o || done_o) bad++;
        end
        check("midrst_abandoned", 64'(bad), 64'd0);

        // Two identical single-line bursts.
        @(posedge clk); #1;
        req_valid_i = 1'b1; req_addr_i = 64'h1000; req_len_i = 8'd0; req_size_i = 3'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        hs = 0; dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (inval_valid_o && inval_ready_i) hs++;
            if (done_o) dn++;
        end
`ifdef INVAL_COALESCE_EN
        check("dup_invals", 64'(hs), 64'd1);
`else
        check("dup_invals", 64'(hs), 64'd2);
`endif
        check("dup_dones", 64'(dn), 64'd2);

        // Randomized traffic against the model.
        do_reset();
        exp_q.delete();
        exp_done = 0; seen_done = 0;
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(posedge clk); #1;
            req_valid_i   = ($urandom_range(0, 99) < 40);
            en_i          = ($urandom_range(0, 99) < 90);
            inval_ready_i = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 7) == 0) req_addr_i = {$urandom(), $urandom()};
            else req_addr_i = 64'($urandom_range(0, 511));
            req_len_i  = 8'($urandom_range(0, 7));
            req_size_i = 3'($urandom_range(0, 4));
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0; en_i = 1'b1; inval_ready_i = 1'b1;
        k = 0;
        while (k < 3000 && (exp_q.size() != 0 || busy_o)) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rand_drained", 64'(exp_q.size()), 64'd0);
        check("rand_dones", 64'(seen_done), 64'(exp_done));
        check("rand_idle", 64'(busy_o), 64'd0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
